inst_dispatch: RTL

- Parametrised instruction dispatcher, next generation of the top-level instruction controller.
- Pops instructions from a first-word-fall-through instruction FIFO and decodes the opcode as a target channel index.
- Waits on a per-instruction dependency mask and a serialisation group, then issues a one-cycle conf pulse with a registered payload to one of N_CH engines (compute, weight/bias/data load, write-back).
- Adds illegal-opcode trapping, a stall timeout, halt, and issue counting.

---
 rtl/dispatch_pkg.sv | 31 +++
 rtl/dispatch_timer.sv | 36 +++
 rtl/inst_dispatch.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/dispatch_pkg.sv
// Shared types and helpers for the instruction dispatcher: FSM states,
// instruction field offsets and the per-instruction readiness check.
package dispatch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      ISSUE = 2'd2,
      GUARD = 2'd3
   } state_e;

   // Field offsets of the default instruction layout: opcode, dep mask, payload.
   localparam int OP_LSB  = 0;
   localparam int DEP_LSB = OP_LSB + 4;
   localparam int PAY_LSB = DEP_LSB + 5;

   // Channel vectors are zero-extended to this width before the readiness check.
   localparam int CH_MAX = 16;

   function automatic logic ready_chk(input logic [3:0]        op,
                                      input logic [CH_MAX-1:0] dep,
                                      input logic [CH_MAX-1:0] idle,
                                      input logic [CH_MAX-1:0] mask);
      logic rdy;
      rdy = idle[op]
            && ((dep & ~idle) == '0)
            && (!mask[op] || ((mask & ~idle) == '0));
      return rdy;
   endfunction

endpackage

// File: rtl/dispatch_timer.sv
// Saturating stall counter; flags a single hit when the count reaches a
// nonzero limit while the dispatcher is still waiting.
module dispatch_timer #(
   parameter int TO_W = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clr,
   input  logic            inc,
   input  logic [TO_W-1:0] lim,
   output logic            hit
);

   logic [TO_W-1:0] cnt_q;
   logic [TO_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign hit = inc && (lim != '0) && (cnt_q == lim);

endmodule

// File: rtl/inst_dispatch.sv
// Instruction dispatcher: pops FWFT instruction words, waits on dependency
// and DDR-serialisation conditions, and issues a one-hot conf pulse per word.
module inst_dispatch
   import dispatch_pkg::*;
#(
   parameter int             INST_LEN    = 256,
   parameter int             OP_W        = DEP_LSB - OP_LSB,
   parameter int             N_CH        = PAY_LSB - DEP_LSB,
   parameter int             PAYLOAD_W   = INST_LEN - OP_W - N_CH,
   parameter logic [N_CH-1:0] SERIAL_MASK = 5'b11110,
   parameter int             TO_W        = 16,
   parameter int             CNT_W       = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [INST_LEN-1:0]  inst_data,
   input  logic                 inst_empty,
   output logic                 inst_pop,
   input  logic                 halt,
   input  logic [N_CH-1:0]      ch_idle,
   output logic [N_CH-1:0]      ch_conf,
   output logic [PAYLOAD_W-1:0] payload,
   input  logic [TO_W-1:0]      timeout_lim,
   input  logic                 err_clr,
   output logic                 err_illegal,
   output logic                 err_timeout,
   output logic                 busy,
   output logic [CNT_W-1:0]     issue_cnt
);

   localparam int DEP_L = OP_LSB + OP_W;
   localparam int PAY_L = DEP_L + N_CH;
   localparam logic [OP_W:0] N_CH_V = (OP_W + 1)'(N_CH);

   state_e               state_q, state_d;
   logic                 inst_pop_q, inst_pop_d;
   logic [N_CH-1:0]      ch_conf_q, ch_conf_d;
   logic [PAYLOAD_W-1:0] payload_q, payload_d;
   logic [CNT_W-1:0]     issue_cnt_q, issue_cnt_d;
   logic                 err_illegal_q, err_illegal_d;
   logic                 err_timeout_q, err_timeout_d;

   logic [OP_W-1:0]      op;
   logic [N_CH-1:0]      dep;
   logic                 legal;
   logic                 ready;
   logic                 set_ill;
   logic                 tmr_inc;
   logic                 tmr_clr;
   logic                 tmr_hit;

   assign op    = inst_data[OP_LSB +: OP_W];
   assign dep   = inst_data[DEP_L +: N_CH];
   assign legal = ({1'b0, op} < N_CH_V);
   assign ready = legal && !halt
                  && ready_chk(4'(op), CH_MAX'(dep), CH_MAX'(ch_idle), CH_MAX'(SERIAL_MASK));

   // The counter only runs while one instruction is stalled in CHECK.
   assign tmr_clr = (state_q != CHECK);

   dispatch_timer #(
      .TO_W (TO_W)
   ) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (tmr_clr),
      .inc   (tmr_inc),
      .lim   (timeout_lim),
      .hit   (tmr_hit)
   );

   always_comb begin
      state_d     = state_q;
      inst_pop_d  = 1'b0;
      ch_conf_d   = '0;
      payload_d   = payload_q;
      issue_cnt_d = issue_cnt_q;
      set_ill     = 1'b0;
      tmr_inc     = 1'b0;
      case (state_q)
         IDLE: begin
            // Wait out an illegal-word pop so the old head is not decoded twice.
            if (!inst_empty && !halt && !inst_pop_q) begin
               state_d = CHECK;
            end
         end
         CHECK: begin
            if (inst_empty) begin
               state_d = IDLE;
            end else if (!legal) begin
               inst_pop_d = 1'b1;
               set_ill    = 1'b1;
               state_d    = IDLE;
            end else if (ready) begin
               payload_d  = inst_data[PAY_L +: PAYLOAD_W];
               ch_conf_d  = N_CH'(1) << op;
               inst_pop_d = 1'b1;
               state_d    = ISSUE;
            end else begin
               tmr_inc = 1'b1;
            end
         end
         ISSUE: begin
            issue_cnt_d = issue_cnt_q + 1'b1;
            state_d     = GUARD;
         end
         GUARD: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // A same-cycle set beats the clear.
      err_illegal_d = set_ill | (err_illegal_q & ~err_clr);
      err_timeout_d = tmr_hit | (err_timeout_q & ~err_clr);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         inst_pop_q    <= 1'b0;
         ch_conf_q     <= '0;
         payload_q     <= '0;
         issue_cnt_q   <= '0;
         err_illegal_q <= 1'b0;
         err_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         inst_pop_q    <= inst_pop_d;
         ch_conf_q     <= ch_conf_d;
         payload_q     <= payload_d;
         issue_cnt_q   <= issue_cnt_d;
         err_illegal_q <= err_illegal_d;
         err_timeout_q <= err_timeout_d;
      end
   end

   assign inst_pop    = inst_pop_q;
   assign ch_conf     = ch_conf_q;
   assign payload     = payload_q;
   assign issue_cnt   = issue_cnt_q;
   assign err_illegal = err_illegal_q;
   assign err_timeout = err_timeout_q;
   assign busy        = (state_q != IDLE);

endmodule
